nsc8_program_loader: RTL

//  Writer side of the NSC8 program-memory interface. Accepts program bytes over a valid/ready stream and writes them into NSC8 RAM from address 0 upward.

---
 rtl/nsc8_program_loader_if.sv | 26 ++
 rtl/nsc8_program_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/nsc8_program_loader_if.sv
// Byte stream into the loader and the RAM write port out of it.
// The loader is the slave on the stream and the master on the RAM port.
interface nsc8_program_loader_if #(
  parameter int N      = 8,
  parameter int ADDR_W = 4
);
  // Stream handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_valid/in_data/in_last are driven by the source and have no dependency on in_ready.
  logic              in_valid;
  logic [N-1:0]      in_data;
  logic              in_last;
  logic              in_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [N-1:0]      ram_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/nsc8_program_loader.sv
// Loads a program byte stream into NSC8 RAM from address 0, holding the CPU
// in reset until the load finishes plus RST_HOLD settling cycles.
module nsc8_program_loader #(
  parameter int N         = 8,
  parameter int ADDR_W    = 4,
  parameter int RAM_DEPTH = 16,
  parameter int RST_HOLD  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  nsc8_program_loader_if.slave bus,
  output logic              reset_counter,
  output logic              reset_ring,
  output logic              clear_ir,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count,
  output logic [1:0]        state_dbg
);

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  // Debug encoding: IDLE=0, LOAD=1, HOLD=2, RUN=3.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] ptr;
  logic [HW-1:0]     hold_cnt;
  logic              xfer;
  logic              last_xfer;
  logic              cpu_rst_d;
  logic              busy_d;
  logic              done_d;

  assign xfer      = bus.in_valid && (state == LOAD);
  assign last_xfer = xfer && (bus.in_last || (ptr == ADDR_W'(RAM_DEPTH - 1)));
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: if (last_xfer) next_state = HOLD;
      HOLD: if (hold_cnt == HW'(RST_HOLD - 1)) next_state = RUN;
      RUN:  if (start) next_state = LOAD;
      default: next_state = IDLE;
    endcase
  end

  // CPU resets drop one cycle after RUN is entered, so the release lands
  // 1+RST_HOLD cycles after the final transfer; re-entering LOAD asserts them at once.
  always_comb begin
    bus.in_ready = (state == LOAD);
    cpu_rst_d    = !((state == RUN) && (next_state == RUN));
    busy_d       = (next_state == LOAD) || (next_state == HOLD);
    done_d       = (next_state == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reset_counter <= 1'b1;
      reset_ring    <= 1'b1;
      clear_ir      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      reset_counter <= cpu_rst_d;
      reset_ring    <= cpu_rst_d;
      clear_ir      <= cpu_rst_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      byte_count    <= '0;
      ptr           <= '0;
      hold_cnt      <= '0;
    end else begin
      bus.ram_we <= xfer;
      if (xfer) begin
        bus.ram_addr  <= ptr;
        bus.ram_wdata <= bus.in_data;
        ptr           <= ptr + ADDR_W'(1);
        byte_count    <= byte_count + (ADDR_W + 1)'(1);
      end else if (start && (state == IDLE || state == RUN)) begin
        ptr        <= '0;
        byte_count <= '0;
      end
      if (state == HOLD) hold_cnt <= hold_cnt + HW'(1);
      else               hold_cnt <= '0;
    end
  end

endmodule
